// File: rtl/moving_average_param.sv
// Boxcar averager over a runtime-selected power-of-two window (1..2^LOG2_MAX_WIN samples).
// Define MAVG_ROUND_EN to round the average half-up instead of truncating it.
module moving_average_param #(
    parameter int DATA_W       = 10,
    parameter int LOG2_MAX_WIN = 4,
    parameter int SEL_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  win_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              primed,
    output logic              overrun
);

    localparam int DEPTH = 1 << LOG2_MAX_WIN;
    localparam int PW    = LOG2_MAX_WIN;
    localparam int FW    = LOG2_MAX_WIN + 1;
    localparam int SUM_W = DATA_W + LOG2_MAX_WIN;
    localparam int KW    = $clog2(LOG2_MAX_WIN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state_q;
    logic [2:0]        sync_q;
    logic              edge_det;
    logic [KW-1:0]     k_sel;
    logic [KW-1:0]     k_q;
    logic [FW-1:0]     win;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_addr;
    logic [FW-1:0]     fill_q;
    logic [FW-1:0]     fill_d;
    logic              full;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sum_d;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] pend_data_q;
    logic              pend_q;
    logic [DATA_W-1:0] oldest_q;
    logic [DATA_W-1:0] avg_d;
    logic [DATA_W-1:0] data_out_q;
    logic              strobe_out_q;
    logic              primed_q;
    logic              overrun_q;

    logic [DATA_W-1:0] sample_mem [DEPTH];

`ifdef MAVG_ROUND_EN
    logic [SUM_W:0]    rnd_add;
`endif

    // Two synchroniser stages followed by one history flop for the rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], strobe_in};
        end
    end

    assign edge_det = sync_q[1] & ~sync_q[2];

    always_comb begin
        if (32'(win_sel) > 32'(LOG2_MAX_WIN)) begin
            k_sel = KW'(LOG2_MAX_WIN);
        end else begin
            k_sel = KW'(win_sel);
        end
    end

    // At the full window the read address equals the write address; the read-first RAM returns the old sample.
    assign win     = FW'(1) << k_q;
    assign rd_addr = wr_ptr_q - win[PW-1:0];
    assign full    = (fill_q == win);

    always_comb begin
        sum_d  = sum_q + SUM_W'(cur_q) - (full ? SUM_W'(oldest_q) : SUM_W'(0));
        fill_d = full ? fill_q : fill_q + FW'(1);
    end

`ifdef MAVG_ROUND_EN
    always_comb begin
        rnd_add = '0;
        if (k_q != '0) begin
            rnd_add = (SUM_W + 1)'(1) << (k_q - KW'(1));
        end
        avg_d = DATA_W'(({1'b0, sum_d} + rnd_add) >> k_q);
    end
`else
    always_comb begin
        avg_d = DATA_W'(sum_d >> k_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (state_q == READ) begin
            sample_mem[wr_ptr_q] <= cur_q;
            oldest_q             <= sample_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            cur_q        <= '0;
            pend_data_q  <= '0;
            pend_q       <= 1'b0;
            data_out_q   <= '0;
            strobe_out_q <= 1'b0;
            primed_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            strobe_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    k_q <= k_sel;
                    if (k_sel != k_q) begin
                        sum_q     <= '0;
                        fill_q    <= '0;
                        primed_q  <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                    if (!ena) begin
                        pend_q <= 1'b0;
                    end else if (pend_q) begin
                        // The held edge wins; a fresh edge in this same cycle has nowhere to go.
                        cur_q   <= pend_data_q;
                        pend_q  <= 1'b0;
                        state_q <= READ;
                        if (edge_det) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (edge_det) begin
                        cur_q   <= data_in;
                        state_q <= READ;
                    end
                end
                READ: begin
                    state_q <= ACC;
                end
                ACC: begin
                    sum_q        <= sum_d;
                    fill_q       <= fill_d;
                    wr_ptr_q     <= wr_ptr_q + PW'(1);
                    data_out_q   <= avg_d;
                    strobe_out_q <= 1'b1;
                    primed_q     <= (fill_d == win);
                    state_q      <= OUT;
                end
                OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (state_q != IDLE) begin
                if (!ena) begin
                    pend_q <= 1'b0;
                end else if (edge_det) begin
                    if (pend_q) begin
                        overrun_q <= 1'b1;
                    end else begin
                        pend_q      <= 1'b1;
                        pend_data_q <= data_in;
                    end
                end
            end
        end
    end

    assign data_out   = data_out_q;
    assign strobe_out = strobe_out_q;
    assign primed     = primed_q;
    assign overrun    = overrun_q;

endmodule
